// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - memory-to-memory DMA copy engine: CPU register window plus request/grant bus master
module dma_copy_engine #(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        m_req,
    input  logic        m_gnt,
    output logic [31:0] m_a,
    output logic        m_we,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        src;
    logic [31:0]        dst;
    logic [31:0]        rd_buf;
    logic [LEN_W-1:0]   len;
    logic               done;
    logic               busy;
    logic               ctrl_wr;
    logic               abort;

    assign busy    = (state != IDLE);
    assign ctrl_wr = WE && (A == 2'd3);
    assign abort   = ctrl_wr && WD[1];

    // Bus outputs decode straight from the state register, so async reset drops them at once.
    assign m_req = busy;
    assign m_we  = (state == WR_REQ);
    assign m_a   = (state == RD_REQ) ? src :
                   (state == WR_REQ) ? dst : 32'd0;
    assign m_wd  = (state == WR_REQ) ? rd_buf : 32'd0;
    assign irq   = done;

    always_comb begin
        RD = 32'd0;
        case (A)
            2'd0:    RD = src;
            2'd1:    RD = dst;
            2'd2:    RD = {{(32-LEN_W){1'b0}}, len};
            default: RD = {30'd0, done, busy};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            src    <= 32'd0;
            dst    <= 32'd0;
            rd_buf <= 32'd0;
            len    <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (WE) begin
                        case (A)
                            2'd0: src <= WD;
                            2'd1: dst <= WD;
                            2'd2: len <= WD[LEN_W-1:0];
                            default: begin
                                // A zero-length start completes immediately without touching the bus.
                                if (WD[0]) begin
                                    done <= (len == '0);
                                    if (len != '0)
                                        state <= RD_REQ;
                                end else if (WD[2]) begin
                                    done <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                RD_REQ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (m_gnt) begin
                        rd_buf <= m_rd;
                        src    <= src + ADDR_STEP;
                        state  <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (m_gnt) begin
                        dst <= dst + ADDR_STEP;
                        len <= len - LEN_W'(1);
                        if (len == LEN_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - self-checking bench for dma_copy_engine with a word-level copy reference model
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  A = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] WD = 32'd0;
    logic [31:0] RD;
    logic        m_req;
    logic        m_gnt = 1'b0;
    logic [31:0] m_a;
    logic        m_we;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] dmem [64];
    logic [31:0] seed_mem [64];
    logic        load_mem = 1'b0;

    always #5 clk = ~clk;

    dma_copy_engine #(.LEN_W(16), .ADDR_STEP(32'd4)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .WE    (WE),
        .WD    (WD),
        .RD    (RD),
        .m_req (m_req),
        .m_gnt (m_gnt),
        .m_a   (m_a),
        .m_we  (m_we),
        .m_wd  (m_wd),
        .m_rd  (m_rd),
        .irq   (irq)
    );

    // Bus-side memory: 64 words decoded by address bits [7:2].
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) dmem[i] <= seed_mem[i];
        end else if (m_req && m_gnt && m_we) begin
            dmem[m_a[7:2]] <= m_wd;
        end
    end
    assign m_rd = dmem[m_a[7:2]];

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        A = a;
        WD = d;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = RD;
    endtask

    task automatic load_memory;
        load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
    endtask

    // mode 0: grant always, 1: grant pattern 1-0-0, 2: random grant
    task automatic do_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input int len, input int mode);
        logic [31:0] refm [64];
        logic [31:0] exp_wd [$];
        logic [31:0] sa, da, v, pv_a, pv_wd;
        logic        g, pv_req, pv_gnt, pv_we;
        int          k, rbeats, wbeats, errs;
        for (int i = 0; i < 64; i++) refm[i] = dmem[i];
        for (int i = 0; i < len; i++) begin
            sa = s + 32'(i) * 32'd4;
            da = d + 32'(i) * 32'd4;
            refm[da[7:2]] = refm[sa[7:2]];
            exp_wd.push_back(refm[da[7:2]]);
        end
        reg_write(2'd0, s);
        reg_write(2'd1, d);
        reg_write(2'd2, 32'(len));
        m_gnt = (mode == 0);
        reg_write(2'd3, 32'd1);
        k = 1; rbeats = 0; wbeats = 0;
        pv_req = 1'b0; pv_gnt = 1'b1; pv_a = 32'd0; pv_wd = 32'd0; pv_we = 1'b0;
        while (!irq && k < 400) begin
            if (pv_req && !pv_gnt) begin
                chk({tag, " stall_m_a"}, m_a, pv_a);
                chk({tag, " stall_m_we"}, {31'd0, m_we}, {31'd0, pv_we});
                chk({tag, " stall_m_wd"}, m_wd, pv_wd);
            end
            chk({tag, " we_outside_req"}, {31'd0, m_we & ~m_req}, 32'd0);
            case (mode)
                0:       g = 1'b1;
                1:       g = ((k % 3) == 1);
                default: g = 1'($urandom_range(0, 1));
            endcase
            m_gnt = g;
            if (m_req && g) begin
                if (m_we) begin
                    chk({tag, " wr_addr"}, m_a, d + 32'(wbeats) * 32'd4);
                    if (wbeats < exp_wd.size()) chk({tag, " wr_data"}, m_wd, exp_wd[wbeats]);
                    wbeats++;
                end else begin
                    chk({tag, " rd_addr"}, m_a, s + 32'(rbeats) * 32'd4);
                    rbeats++;
                end
            end
            pv_req = m_req; pv_gnt = g; pv_a = m_a; pv_we = m_we; pv_wd = m_wd;
            @(negedge clk);
            k++;
        end
        m_gnt = 1'b0;
        chk({tag, " done_seen"}, {31'd0, irq}, 32'd1);
        if (mode == 0) chk({tag, " done_cycle"}, 32'(k), 32'(2 * len + 1));
        chk({tag, " beats"}, 32'(rbeats + wbeats), 32'(2 * len));
        errs = 0;
        for (int i = 0; i < 64; i++) if (dmem[i] !== refm[i]) errs++;
        chk({tag, " mem_words_wrong"}, 32'(errs), 32'd0);
        reg_read(2'd2, v); chk({tag, " remaining"}, v, 32'd0);
        reg_read(2'd0, v); chk({tag, " src_end"}, v, s + 32'(len) * 32'd4);
        reg_read(2'd1, v); chk({tag, " dst_end"}, v, d + 32'(len) * 32'd4);
        reg_read(2'd3, v); chk({tag, " status"}, v, 32'd2);
    endtask

    initial begin
        logic [31:0] v, w0, w1;
        int          k;

        for (int i = 0; i < 64; i++) seed_mem[i] = $urandom;
        seed_mem[4] = 32'hAAAA_0001;
        seed_mem[5] = 32'hAAAA_0002;
        seed_mem[6] = 32'hAAAA_0003;

        // Reset state, held in reset
        @(negedge clk);
        load_memory();
        chk("rst m_req", {31'd0, m_req}, 32'd0);
        chk("rst m_we", {31'd0, m_we}, 32'd0);
        chk("rst m_a", m_a, 32'd0);
        chk("rst m_wd", m_wd, 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            reg_read(2'(i), v);
            chk($sformatf("rst reg%0d", i), v, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Register window vectors in IDLE
        vecs[0] = '{1'b1, 2'd0, 32'h1234_5678, 2'd0, 32'h1234_5678};
        vecs[1] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 2'd2, 32'hABCD_0007, 2'd2, 32'h0000_0007};
        vecs[3] = '{1'b1, 2'd3, 32'h0000_0002, 2'd3, 32'h0000_0000};
        vecs[4] = '{1'b1, 2'd3, 32'h0000_0004, 2'd3, 32'h0000_0000};
        vecs[5] = '{1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h1234_5678};
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].we) reg_write(vecs[i].a, vecs[i].wd);
            else @(negedge clk);
            reg_read(vecs[i].ra, v);
            chk($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        // Async reset in the middle of a transfer
        reg_write(2'd0, 32'h10);
        reg_write(2'd1, 32'h40);
        reg_write(2'd2, 32'd2);
        m_gnt = 1'b0;
        reg_write(2'd3, 32'd1);
        chk("mid m_req", {31'd0, m_req}, 32'd1);
        reg_read(2'd3, v); chk("mid status", v, 32'd1);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        chk("mid m_we", {31'd0, m_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async m_req", {31'd0, m_req}, 32'd0);
        chk("async m_we", {31'd0, m_we}, 32'd0);
        reg_read(2'd3, v); chk("async status", v, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst m_req", {31'd0, m_req}, 32'd0);
        reg_read(2'd3, v); chk("post_rst status", v, 32'd0);
        reg_read(2'd0, v); chk("post_rst src", v, 32'd0);

        // Basic three-word copy, grant tied high
        do_copy("basic", 32'h10, 32'h40, 3, 0);
        chk("basic w0", dmem[16], 32'hAAAA_0001);
        chk("basic w1", dmem[17], 32'hAAAA_0002);
        chk("basic w2", dmem[18], 32'hAAAA_0003);

        // Same transfer with grant stalls
        do_copy("stall", 32'h10, 32'h40, 3, 1);
        chk("stall w2", dmem[18], 32'hAAAA_0003);

        // Zero-length start
        reg_write(2'd2, 32'd0);
        m_gnt = 1'b1;
        reg_write(2'd3, 32'd1);
        chk("len0 m_req", {31'd0, m_req}, 32'd0);
        chk("len0 irq", {31'd0, irq}, 32'd1);
        reg_read(2'd3, v); chk("len0 status", v, 32'd2);
        reg_write(2'd3, 32'd4);
        chk("len0 w1c", {31'd0, irq}, 32'd0);
        m_gnt = 1'b0;

        // Abort after one word of four
        w0 = dmem[8];
        w1 = dmem[25];
        reg_write(2'd0, 32'h20);
        reg_write(2'd1, 32'h60);
        reg_write(2'd2, 32'd4);
        m_gnt = 1'b1;
        reg_write(2'd3, 32'd1);
        repeat (2) @(negedge clk);
        m_gnt = 1'b0;
        reg_write(2'd3, 32'd2);
        reg_read(2'd3, v); chk("abort status", v, 32'd0);
        chk("abort m_req", {31'd0, m_req}, 32'd0);
        chk("abort irq", {31'd0, irq}, 32'd0);
        reg_read(2'd2, v); chk("abort len", v, 32'd3);
        reg_read(2'd0, v); chk("abort src", v, 32'h24);
        reg_read(2'd1, v); chk("abort dst", v, 32'h64);
        chk("abort word0", dmem[24], w0);
        chk("abort word1", dmem[25], w1);

        // Writes while busy are ignored
        reg_write(2'd0, 32'h10);
        reg_write(2'd1, 32'h80);
        reg_write(2'd2, 32'd3);
        m_gnt = 1'b0;
        reg_write(2'd3, 32'd1);
        reg_write(2'd0, 32'h999);
        reg_write(2'd1, 32'h4);
        reg_write(2'd2, 32'd5);
        reg_write(2'd3, 32'd1);
        reg_read(2'd0, v); chk("busy src", v, 32'h10);
        reg_read(2'd1, v); chk("busy dst", v, 32'h80);
        reg_read(2'd2, v); chk("busy len", v, 32'd3);
        reg_read(2'd3, v); chk("busy status", v, 32'd1);
        chk("busy m_a", m_a, 32'h10);
        m_gnt = 1'b1;
        k = 0;
        while (!irq && k < 50) begin
            @(negedge clk);
            k++;
        end
        m_gnt = 1'b0;
        chk("busy done", {31'd0, irq}, 32'd1);
        reg_read(2'd2, v); chk("busy remaining", v, 32'd0);
        reg_read(2'd0, v); chk("busy src_end", v, 32'h1C);
        chk("busy w0", dmem[32], 32'hAAAA_0001);
        chk("busy w2", dmem[34], 32'hAAAA_0003);

        // Address wrap, then write-1-to-clear of done
        do_copy("wrap", 32'hFFFF_FFFC, 32'h0000_00C0, 2, 0);
        reg_write(2'd3, 32'd4);
        chk("wrap w1c irq", {31'd0, irq}, 32'd0);

        // Randomized transfers against the reference model
        for (int t = 0; t < 8; t++) begin
            do_copy($sformatf("rand%0d", t), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
